// File: rtl/inst_fetch_if.sv
// Bus bundle for the instruction fetch unit. It carries the memory read port,
// the instruction ready/consume handshake and the branch redirect.
// The master side is the fetch unit. The slave side is the memory plus
// control unit.
interface inst_fetch_if;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_data_i;
   logic [31:0] inst_o;
   logic        inst_ready_o;
   logic        inst_consume_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;

   modport master (
      output mem_req_o, mem_addr_o, inst_o, inst_ready_o,
      input  mem_ack_i, mem_data_i, inst_consume_i, redirect_i, redirect_pc_i
   );

   modport slave (
      input  mem_req_o, mem_addr_o, inst_o, inst_ready_o,
      output mem_ack_i, mem_data_i, inst_consume_i, redirect_i, redirect_pc_i
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit. It keeps the PC and issues one word read at a time.
// A read is only issued when a FIFO slot is free, so a returning word always
// has room. Buffered words are presented on a ready/consume handshake.
// A redirect flushes the FIFO. If a read is still in flight, its eventual ack
// is discarded before fetch restarts at the new PC.
// Every output comes straight from a flop.
module inst_fetch #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter int          DEPTH     = 4
) (
   input  logic          clk_i,
   input  logic          reset_i,
   inst_fetch_if.master  bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic {IDLE, REQ} state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        addr_q, addr_d;
   logic               discard_q, discard_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [31:0]        fifo_q [DEPTH];
   logic [31:0]        inst_q, inst_d;
   logic               ready_q, ready_d;
   logic               pop, ack, push;

   // Next-state, FIFO bookkeeping and registered-output values
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      pop       = ready_q && bus.inst_consume_i;
      ack       = (state_q == REQ) && bus.mem_ack_i;
      push      = 1'b0;
      state_d   = state_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      discard_d = discard_q;
      count_d   = count_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;

      if (bus.redirect_i) begin
         // Redirect wins over any same-edge push, pop or ack data
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         pc_d     = {bus.redirect_pc_i[31:2], 2'b00};
         if (state_q == REQ && !ack) begin
            // Old read must still complete on its own address; drop its data later
            discard_d = 1'b1;
         end else begin
            discard_d = 1'b0;
            state_d   = IDLE;
            addr_d    = pc_d;
         end
      end else begin
         if (ack) begin
            if (discard_q) begin
               discard_d = 1'b0;
            end else begin
               push = 1'b1;
               pc_d = pc_q + 32'd4;
            end
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

         unique case (state_q)
            IDLE: begin
               state_d = (count_d < CNT_W'(DEPTH)) ? REQ : IDLE;
               addr_d  = pc_d;
            end
            REQ: begin
               // Request and address hold until acked, then reissue only if a slot is free
               if (ack) begin
                  state_d = (count_d < CNT_W'(DEPTH)) ? REQ : IDLE;
                  addr_d  = pc_d;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Head after this edge is either the word being written now or an older entry
      ready_d = (count_d != '0);
      if (!ready_d)
         inst_d = '0;
      else if (push && (wr_ptr_q == rd_ptr_d))
         inst_d = bus.mem_data_i;
      else
         inst_d = fifo_q[rd_ptr_d];
   end

   // Control state, PC and output registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!reset_i) begin
         state_q   <= IDLE;
         pc_q      <= {RESET_VEC[31:2], 2'b00};
         addr_q    <= {RESET_VEC[31:2], 2'b00};
         discard_q <= 1'b0;
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         inst_q    <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         addr_q    <= addr_d;
         discard_q <= discard_d;
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         inst_q    <= inst_d;
         ready_q   <= ready_d;
      end
   end

   // FIFO storage write port
   always_ff @(posedge clk_i) begin
      // NOTE: storage is not reset; the count and pointers decide what is valid.
      if (push) fifo_q[wr_ptr_q] <= bus.mem_data_i;
   end

   assign bus.mem_req_o    = (state_q == REQ);
   assign bus.mem_addr_o   = addr_q;
   assign bus.inst_o       = inst_q;
   assign bus.inst_ready_o = ready_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch.
// A per-cycle vector table covers reset, the redirect corners and reset
// mid-operation. A wrap-around sequence runs on a second instance.
// A memory responder plus a scoreboard cover streaming and backpressure.
module tb_inst_fetch;

   logic clk_i = 1'b0;
   logic reset_i;
   always #5 clk_i = ~clk_i;

   inst_fetch_if m ();
   inst_fetch_if w ();

   inst_fetch #(.RESET_VEC(32'h0000_0100), .DEPTH(4)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (m.master)
   );

   inst_fetch #(.RESET_VEC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (w.master)
   );

   typedef struct {
      logic        rst;
      logic        ack;
      logic [31:0] data;
      logic        consume;
      logic        redirect;
      logic [31:0] rpc;
      logic        req;
      logic [31:0] addr;
      logic        rdy;
      logic        chk_inst;
      logic [31:0] inst;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] ack_log [$];
   bit          mem_en = 1'b0;
   bit          cons_en = 1'b0;
   int          wait_states = 0;
   int          wait_cnt = 0;
   logic [31:0] wrap_exp [3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s", name);
   endtask

   // One clock: memory responder and consumer act #1 after the edge
   task automatic cycle();
      @(posedge clk_i);
      #1;
      m.mem_ack_i = 1'b0;
      if (mem_en) begin
         if (m.mem_req_o) begin
            if (wait_cnt >= wait_states) begin
               m.mem_ack_i  = 1'b1;
               m.mem_data_i = m.mem_addr_o;
               wait_cnt     = 0;
               exp_q.push_back(m.mem_addr_o);
               ack_log.push_back(m.mem_addr_o);
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
      m.inst_consume_i = 1'b0;
      if (cons_en && m.inst_ready_o) begin
         m.inst_consume_i = 1'b1;
         if (exp_q.size() == 0) fail("pop_unexpected");
         else check("pop_data", m.inst_o, exp_q.pop_front());
      end
   endtask

   task automatic do_reset();
      reset_i          = 1'b0;
      m.mem_ack_i      = 1'b0;
      m.inst_consume_i = 1'b0;
      m.redirect_i     = 1'b0;
      exp_q.delete();
      ack_log.delete();
      wait_cnt = 0;
      repeat (2) begin
         @(posedge clk_i);
         #1;
      end
      reset_i = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      //            rst ack data          cons redir rpc            req addr          rdy chk inst
      vecs[0]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,    1'b0, 32'h0000_0100, 1'b0, 1'b1, 32'h0};
      vecs[1]  = '{1'b0, 1'b1, 32'hDEAD,   1'b1, 1'b0, 32'h0,    1'b0, 32'h0000_0100, 1'b0, 1'b1, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,    1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,    1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 1'b1, 32'h100,    1'b0, 1'b0, 32'h0,    1'b1, 32'h0000_0104, 1'b1, 1'b1, 32'h100};
      vecs[5]  = '{1'b1, 1'b1, 32'h104,    1'b0, 1'b0, 32'h0,    1'b1, 32'h0000_0108, 1'b1, 1'b1, 32'h100};
      vecs[6]  = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 32'h2003, 1'b1, 32'h0000_0108, 1'b0, 1'b0, 32'h0};
      vecs[7]  = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,    1'b1, 32'h0000_0108, 1'b0, 1'b0, 32'h0};
      vecs[8]  = '{1'b1, 1'b1, 32'h108,    1'b0, 1'b0, 32'h0,    1'b1, 32'h0000_2000, 1'b0, 1'b0, 32'h0};
      vecs[9]  = '{1'b1, 1'b1, 32'hA000,   1'b0, 1'b0, 32'h0,    1'b1, 32'h0000_2004, 1'b1, 1'b1, 32'hA000};
      vecs[10] = '{1'b1, 1'b1, 32'hA004,   1'b0, 1'b0, 32'h0,    1'b1, 32'h0000_2008, 1'b1, 1'b1, 32'hA000};
      vecs[11] = '{1'b1, 1'b1, 32'hA008,   1'b1, 1'b1, 32'h3000, 1'b0, 32'h0000_3000, 1'b0, 1'b0, 32'h0};
      vecs[12] = '{1'b1, 1'b1, 32'hDEAD,   1'b0, 1'b0, 32'h0,    1'b1, 32'h0000_3000, 1'b0, 1'b0, 32'h0};
      vecs[13] = '{1'b1, 1'b1, 32'hB000,   1'b0, 1'b0, 32'h0,    1'b1, 32'h0000_3004, 1'b1, 1'b1, 32'hB000};
      vecs[14] = '{1'b1, 1'b1, 32'hB004,   1'b1, 1'b0, 32'h0,    1'b1, 32'h0000_3008, 1'b1, 1'b1, 32'hB004};
      vecs[15] = '{1'b1, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0,    1'b1, 32'h0000_3008, 1'b0, 1'b0, 32'h0};
      vecs[16] = '{1'b1, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0,    1'b1, 32'h0000_3008, 1'b0, 1'b0, 32'h0};
      vecs[17] = '{1'b1, 1'b1, 32'hC000,   1'b0, 1'b0, 32'h0,    1'b1, 32'h0000_300C, 1'b1, 1'b1, 32'hC000};
      vecs[18] = '{1'b1, 1'b1, 32'hC004,   1'b0, 1'b0, 32'h0,    1'b1, 32'h0000_3010, 1'b1, 1'b1, 32'hC000};
      vecs[19] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,    1'b0, 32'h0000_0100, 1'b0, 1'b1, 32'h0};
      vecs[20] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,    1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0};

      reset_i          = 1'b0;
      m.mem_ack_i      = 1'b0;
      m.mem_data_i     = '0;
      m.inst_consume_i = 1'b0;
      m.redirect_i     = 1'b0;
      m.redirect_pc_i  = '0;
      w.mem_ack_i      = 1'b0;
      w.mem_data_i     = '0;
      w.inst_consume_i = 1'b0;
      w.redirect_i     = 1'b0;
      w.redirect_pc_i  = '0;
      #1;

      // Cycle-accurate vectors: inputs for one cycle, outputs after the next edge
      for (int i = 0; i < NV; i++) begin
         reset_i          = vecs[i].rst;
         m.mem_ack_i      = vecs[i].ack;
         m.mem_data_i     = vecs[i].data;
         m.inst_consume_i = vecs[i].consume;
         m.redirect_i     = vecs[i].redirect;
         m.redirect_pc_i  = vecs[i].rpc;
         @(posedge clk_i);
         #1;
         check($sformatf("v%0d_req", i), m.mem_req_o, vecs[i].req);
         check($sformatf("v%0d_addr", i), m.mem_addr_o, vecs[i].addr);
         check($sformatf("v%0d_rdy", i), m.inst_ready_o, vecs[i].rdy);
         if (vecs[i].chk_inst) check($sformatf("v%0d_inst", i), m.inst_o, vecs[i].inst);
      end
      m.mem_ack_i      = 1'b0;
      m.inst_consume_i = 1'b0;
      m.redirect_i     = 1'b0;

      // PC wrap-around on the second instance, zero-wait acks
      check("wrap_req", w.mem_req_o, 1'b1);
      check("wrap_addr0", w.mem_addr_o, 32'hFFFF_FFF8);
      for (int i = 0; i < 3; i++) begin
         w.mem_ack_i  = 1'b1;
         w.mem_data_i = w.mem_addr_o;
         @(posedge clk_i);
         #1;
         check($sformatf("wrap_addr%0d", i + 1), w.mem_addr_o, wrap_exp[i]);
         if (i == 0) check("wrap_inst", w.inst_o, 32'hFFFF_FFF8);
      end
      w.mem_ack_i = 1'b0;

      // First fetch with two wait states and no consumer
      do_reset();
      wait_states = 2;
      mem_en      = 1'b1;
      cons_en     = 1'b0;
      for (int i = 0; i < 60 && ack_log.size() < 4; i++) cycle();
      if (ack_log.size() < 4) fail("first_fetch_timeout");
      repeat (6) cycle();
      check("ff_ack_count", ack_log.size(), 4);
      check("ff_req_idle", m.mem_req_o, 1'b0);
      for (int i = 0; i < 4 && i < ack_log.size(); i++)
         check($sformatf("ff_addr%0d", i), ack_log[i], 32'h100 + 32'(4 * i));
      check("ff_head", m.inst_o, 32'h100);
      cons_en = 1'b1;
      repeat (30) cycle();

      // Backpressure with zero-wait memory, then a single pop
      do_reset();
      wait_states = 0;
      cons_en     = 1'b0;
      repeat (12) cycle();
      check("bp_ack_count", ack_log.size(), 4);
      check("bp_req_idle", m.mem_req_o, 1'b0);
      check("bp_ready", m.inst_ready_o, 1'b1);
      cons_en = 1'b1;
      cycle();
      cons_en = 1'b0;
      repeat (10) cycle();
      check("bp_ack_after_pop", ack_log.size(), 5);
      if (ack_log.size() == 5) check("bp_addr_after_pop", ack_log[4], 32'h110);
      check("bp_req_idle2", m.mem_req_o, 1'b0);

      // Sustained streaming: one word per cycle with zero wait states
      cons_en = 1'b1;
      repeat (10) cycle();
      base = ack_log.size();
      repeat (20) cycle();
      check("stream_rate", ack_log.size() - base, 20);
      wait_states = 1;
      repeat (30) cycle();

      // Drain: stop the memory, consumer empties the FIFO
      mem_en = 1'b0;
      repeat (10) cycle();
      check("drain_sb_empty", exp_q.size(), 0);
      check("drain_ready", m.inst_ready_o, 1'b0);
      cons_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
